// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, STEPS quotient bits per clock.
// Divide-by-zero takes a one-cycle shortcut and flags div_zero.
module seq_divider #(
  parameter int DIVIDEND_W = 1026,
  parameter int DIVISOR_W  = 1024,
  parameter int STEPS      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  localparam int N  = DIVIDEND_W / STEPS;
  localparam int CW = $clog2(N + 1);

  generate
    if (!(STEPS == 1 || STEPS == 2 || STEPS == 4)
        || (DIVIDEND_W % STEPS) != 0) begin : g_bad
      $error("seq_divider: illegal STEPS/DIVIDEND_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZERO
  } state_t;

  state_t state;

  // qsh shifts dividend bits out of the top and quotient bits in at the bottom
  logic [DIVIDEND_W-1:0] qsh;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    prem;
  logic [CW-1:0]         cnt;

  logic [DIVIDEND_W-1:0] q_nxt;
  logic [DIVISOR_W:0]    r_nxt;

  always_comb begin
    q_nxt = qsh;
    r_nxt = prem;
    for (int i = 0; i < STEPS; i++) begin
      r_nxt = {r_nxt[DIVISOR_W-1:0], q_nxt[DIVIDEND_W-1]};
      q_nxt = {q_nxt[DIVIDEND_W-2:0], 1'b0};
      if (r_nxt >= {1'b0, dvs}) begin
        r_nxt    = r_nxt - {1'b0, dvs};
        q_nxt[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qsh       <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            qsh  <= dividend;
            dvs  <= divisor;
            busy <= 1'b1;
            if (divisor != '0) begin
              prem     <= '0;
              cnt      <= CW'(N);
              div_zero <= 1'b0;
              state    <= RUN;
            end else begin
              state <= ZERO;
            end
          end
        end
        RUN: begin
          qsh  <= q_nxt;
          prem <= r_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[DIVISOR_W-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= DIVISOR_W'(qsh);
          div_zero  <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: 8/4-bit instances (STEPS 1 and 4) plus the
// default-width instance, checked against plain integer division.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_s [2];
  logic [7:0] dvd_s   [2];
  logic [3:0] dvs_s   [2];
  logic [7:0] q_s     [2];
  logic [3:0] r_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       dz_s    [2];

  logic          bstart;
  logic [1025:0] bdvd;
  logic [1023:0] bdvs;
  logic [1025:0] bq;
  logic [1023:0] br;
  logic          bbusy, bdone, bdz;

  int tests = 0;
  int fails = 0;

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4), .STEPS(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .dividend(dvd_s[0]), .divisor(dvs_s[0]),
    .quotient(q_s[0]), .remainder(r_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .div_zero(dz_s[0])
  );

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4), .STEPS(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .dividend(dvd_s[1]), .divisor(dvs_s[1]),
    .quotient(q_s[1]), .remainder(r_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .div_zero(dz_s[1])
  );

  seq_divider u_big (
    .clk(clk), .rst(rst), .start(bstart),
    .dividend(bdvd), .divisor(bdvs),
    .quotient(bq), .remainder(br),
    .busy(bbusy), .done(bdone), .div_zero(bdz)
  );

  task automatic chk(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // called at posedge+1; the next edge samples the request
  task automatic launch(int w, logic [7:0] a, logic [3:0] b);
    start_s[w] = 1'b1;
    dvd_s[w]   = a;
    dvs_s[w]   = b;
    @(posedge clk); #1;
    start_s[w] = 1'b0;
    dvd_s[w]   = 8'($urandom);
    dvs_s[w]   = 4'($urandom);
  endtask

  task automatic wait_done(int w, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_s[w]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic div8(int w, int a, int b);
    int lat, eq, er, en;
    launch(w, a[7:0], b[3:0]);
    wait_done(w, lat);
    if (b == 0) begin
      eq = 255; er = a % 16; en = 1;
    end else begin
      eq = a / b; er = a % b; en = (w == 0) ? 8 : 2;
    end
    chk("latency", longint'(lat), longint'(en));
    chk("quotient", longint'(q_s[w]), longint'(eq));
    chk("remainder", longint'(r_s[w]), longint'(er));
    chk("div_zero", longint'(dz_s[w]), longint'(b == 0));
    chk("busy_at_done", longint'(busy_s[w]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd;
    logic [1025:0] bq_exp, tmp;
    logic [2049:0] prod;

    for (int w = 0; w < 2; w++) begin
      start_s[w] = 1'b0; dvd_s[w] = '0; dvs_s[w] = '0;
    end
    bstart = 1'b0; bdvd = '0; bdvs = '0;

    #1;
    chk("rst_busy", longint'(busy_s[0]), 0);
    chk("rst_done", longint'(done_s[0]), 0);
    chk("rst_q", longint'(q_s[0]), 0);
    chk("rst_r", longint'(r_s[1]), 0);
    chk("rst_dz", longint'(dz_s[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    div8(0, 200, 7);
    @(posedge clk); #1;
    chk("done_pulse", longint'(done_s[0]), 0);
    chk("hold_q", longint'(q_s[0]), 28);
    chk("hold_r", longint'(r_s[0]), 4);

    div8(1, 200, 7);
    div8(0, 55, 0);
    div8(1, 55, 0);
    div8(0, 5, 9);
    div8(1, 255, 1);
    div8(0, 255, 15);

    for (int i = 0; i < 24; i++)
      div8(i % 2, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));

    // a second start during RUN must be ignored
    launch(0, 8'd200, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    start_s[0] = 1'b1; dvd_s[0] = 8'd9; dvs_s[0] = 4'd3;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("ign_busy", longint'(busy_s[0]), 1);
    wait_done(0, lat);
    chk("ign_latency", longint'(lat + 4), 8);
    chk("ign_q", longint'(q_s[0]), 28);
    chk("ign_r", longint'(r_s[0]), 4);

    // asynchronous reset abandons a division in flight
    launch(0, 8'd200, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", longint'(busy_s[0]), 0);
    chk("arst_q", longint'(q_s[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_s[0]) nd++;
    end
    chk("arst_no_done", longint'(nd), 0);
    rst = 1'b1;
    #3;
    @(posedge clk); #1;
    rst = 1'b0;
    div8(0, 200, 7);

    // back-to-back: start in the done cycle
    div8(0, 200, 7);
    chk("b2b_done_high", longint'(done_s[0]), 1);
    div8(0, 9, 3);

    // default widths
    bdvd = '0;
    bdvd[1024] = 1'b1;
    for (int i = 0; i < 32; i++) bdvs[i*32 +: 32] = $urandom;
    bdvs[0] = 1'b1;
    bq_exp = bdvd / {2'b00, bdvs};
    tmp = bdvd % {2'b00, bdvs};
    bstart = 1'b1;
    @(posedge clk); #1;
    bstart = 1'b0;
    tmp = tmp;
    lat = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (bdone) begin
        lat = k;
        break;
      end
    end
    bdvd = '1;
    chk("big_latency", longint'(lat), 1026);
    chk("big_q", longint'(bq === bq_exp), 1);
    chk("big_r", longint'(br === tmp[1023:0]), 1);
    prod = {1024'b0, bq} * {1026'b0, br == br ? bdvs : bdvs} + {1026'b0, br};
    chk("big_identity", longint'(prod === {1024'b0, 2'b01, 1024'b0}), 1);
    chk("big_rem_lt", longint'(br < bdvs), 1);
    chk("big_dz", longint'(bdz), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 1026: dividend and quotient width in bits.
REQ-002 Parameter DIVISOR_W, default 1024: divisor and remainder width in bits.
REQ-003 Parameter STEPS, default 1: restoring-division steps per clock; legal values 1, 2, 4; DIVIDEND_W SHALL be divisible by STEPS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a division; sampled on a rising edge only in IDLE.
REQ-007 dividend  input  DIVIDEND_W  numerator, unsigned; sampled with start.
REQ-008 divisor  input  DIVISOR_W  denominator, unsigned; sampled with start.
REQ-009 quotient  output  DIVIDEND_W  registered result floor(dividend/divisor).
REQ-010 remainder  output  DIVISOR_W  registered result dividend mod divisor.
REQ-011 busy  output  1  high while a division is in progress.
REQ-012 done  output  1  one-cycle pulse marking valid quotient and remainder.
REQ-013 div_zero  output  1  registered flag; high when the last accepted divisor was 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and ZERO.
REQ-015 IDLE with start=1 and divisor!=0: latch operands, clear partial remainder, load step counter with N=DIVIDEND_W/STEPS, go to RUN, set busy=1, clear div_zero.
REQ-016 IDLE with start=1 and divisor==0: go to ZERO, set busy=1.
REQ-017 RUN: each edge SHALL perform STEPS restoring steps, MSB first.
REQ-018 One restoring step: R = {R, next dividend bit}; if R >= D then R = R - D and the quotient bit is 1, else the quotient bit is 0.
REQ-019 The partial remainder SHALL be DIVISOR_W+1 bits wide so the comparison never overflows.
REQ-020 The step counter SHALL decrement once per RUN edge.
REQ-021 On the RUN edge where the counter reaches 0: register quotient and remainder, pulse done=1 for one cycle, set busy=0, return to IDLE.
REQ-022 Latency SHALL be exactly N edges from the start-sampling edge to the edge asserting done.
REQ-023 ZERO, one edge after start: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_zero=1, done pulsed, busy=0, return to IDLE.
REQ-024 start while busy=1 SHALL be ignored, with no effect on the ongoing division or latched operands.
REQ-025 start may be asserted in the same cycle done is high; it SHALL be accepted because the FSM is already in IDLE, giving back-to-back operation with no idle gap.
REQ-026 Operand inputs may change freely after the sampling edge without affecting the result.
REQ-027 quotient, remainder and div_zero SHALL hold their values until the next done.
REQ-028 A dividend narrower than the divisor's magnitude SHALL yield quotient=0 and remainder=dividend, with no special case needed.
REQ-029 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0.
REQ-031 rst asserted mid-RUN SHALL abandon the division; no done is produced for it.
REQ-032 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 DIVIDEND_W=8, DIVISOR_W=4, STEPS=1: dividend=200, divisor=7 -> done 8 edges after start, quotient=28, remainder=4, div_zero=0.
REQ-034 Same config with STEPS=4: 200/7 -> done 2 edges after start, quotient=28, remainder=4.
REQ-035 Same config: dividend=55, divisor=0 -> done 1 edge after start, quotient=8'hFF, remainder=7, div_zero=1.
REQ-036 Defaults: dividend=1<<1024 and a random odd 1024-bit divisor -> done after 1026 edges; check REQ-029 with a reference model.
REQ-037 start re-pulsed mid-RUN -> ignored, result unchanged; rst pulsed at step 3 -> busy=0 at once, no done, next 200/7 still correct.
REQ-038 Start asserted in the done cycle with 9/3 -> accepted immediately, quotient=3, remainder=0, 8 edges later.
